// File: rtl/fir_coef_loader_if.sv
// Coefficient-loader bus: configuration/load requests in, FIR coefficient
// stream and sequencing status out.
interface fir_coef_loader_if #(
  parameter int COEF_W = 12
);
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              load_req;
  logic [3:0]        load_sel;

  logic [COEF_W-1:0] coefi;
  logic              coefi_valid;
  logic [3:0]        coef_sel;
  logic              coef_on;
  logic              data_en;
  logic              busy;
  logic              done;
  logic              err;

  // Requester side: issues writes and load requests, observes the stream
  modport master (
    output cfg_we, cfg_addr, cfg_data, load_req, load_sel,
    input  coefi, coefi_valid, coef_sel, coef_on, data_en, busy, done, err
  );

  // Loader side: consumes requests, produces the stream and status
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, load_req, load_sel,
    output coefi, coefi_valid, coef_sel, coef_on, data_en, busy, done, err
  );
endinterface

// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: holds a shadow coefficient file written while idle,
// streams it into the FIR on request, switches the active coefficient set and
// then holds the data path off until the filter pipeline has flushed.
module fir_coef_loader #(
  parameter int TAPS   = 11,
  parameter int COEF_W = 12
) (
  input logic             clk,
  input logic             reset,
  fir_coef_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SWITCH, SETTLE} state_t;

  localparam int               IDX_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t            state;
  logic [COEF_W-1:0] shadow [TAPS];
  logic [IDX_W-1:0]  idx;
  logic [3:0]        sel_q;

  logic              addr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  next_idx;
  logic              reject;

  assign addr_ok  = ({28'd0, bus.cfg_addr} < 32'(TAPS));
  assign wr_idx   = IDX_W'(bus.cfg_addr);
  assign next_idx = idx + 1'b1;
  // Any write or load attempt outside IDLE is refused with a single err pulse
  assign reject   = bus.cfg_we | bus.load_req;

  // Sequencer and shadow file; idx walks the taps in LOAD and counts the
  // flush cycles in SETTLE, always leaving a state at TAPS-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      sel_q           <= '0;
      for (int i = 0; i < TAPS; i++) shadow[i] <= '0;
      bus.coefi       <= '0;
      bus.coefi_valid <= 1'b0;
      bus.coef_sel    <= '0;
      bus.coef_on     <= 1'b0;
      bus.data_en     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.coef_on <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            if (addr_ok) shadow[wr_idx] <= bus.cfg_data;
            else         bus.err        <= 1'b1;
          end
          if (bus.load_req) begin
            state           <= LOAD;
            idx             <= '0;
            sel_q           <= bus.load_sel;
            bus.busy        <= 1'b1;
            bus.data_en     <= 1'b0;
            bus.coefi_valid <= 1'b1;
            // A same-edge write to tap 0 must appear in the stream
            bus.coefi       <= (bus.cfg_we && bus.cfg_addr == 4'd0) ?
                               bus.cfg_data : shadow[0];
          end
        end
        LOAD: begin
          bus.err <= reject;
          if (idx == LAST_IDX) begin
            state           <= SWITCH;
            idx             <= '0;
            bus.coefi       <= '0;
            bus.coefi_valid <= 1'b0;
            bus.coef_on     <= 1'b1;
            bus.coef_sel    <= sel_q;
          end else begin
            idx       <= next_idx;
            bus.coefi <= shadow[next_idx];
          end
        end
        SWITCH: begin
          bus.err <= reject;
          state   <= SETTLE;
          idx     <= '0;
        end
        SETTLE: begin
          bus.err <= reject;
          if (idx == LAST_IDX) begin
            state       <= IDLE;
            idx         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.data_en <= 1'b1;
          end else begin
            idx <= next_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed testbench for fir_coef_loader: each task drives one scenario and
// checks the cycle-by-cycle response against hand-computed values.
module tb_fir_coef_loader;

  localparam int TAPS   = 11;
  localparam int COEF_W = 12;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  // Intended shadow contents, maintained by the bench from its own writes
  logic [COEF_W-1:0] shadow_exp [TAPS];

  fir_coef_loader_if #(.COEF_W(COEF_W)) bus ();

  fir_coef_loader #(.TAPS(TAPS), .COEF_W(COEF_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.load_req = 1'b0;
    bus.load_sel = '0;
  endtask

  // Pulse load_req for one edge; returns observing cycle N+1
  task automatic start_load(input logic [3:0] sel);
    bus.load_sel = sel;
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    tests++;
    if ({bus.coefi, bus.coefi_valid, bus.coef_sel, bus.coef_on, bus.data_en,
         bus.busy, bus.done, bus.err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: coefi=%0h valid=%0b sel=%0h on=%0b den=%0b busy=%0b done=%0b err=%0b, expected all 0",
               bus.coefi, bus.coefi_valid, bus.coef_sel, bus.coef_on, bus.data_en,
               bus.busy, bus.done, bus.err);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (bus.data_en !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: data_en=%0b busy=%0b, expected 0 0", bus.data_en, bus.busy);
    end
  endtask

  task automatic test_basic_load();
    for (int i = 0; i < TAPS; i++) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 4'(i);
      bus.cfg_data  = COEF_W'(i + 1);
      shadow_exp[i] = COEF_W'(i + 1);
      tick();
    end
    bus.cfg_we = 1'b0;
    start_load(4'd3);
    for (int k = 1; k <= TAPS; k++) begin
      tests++;
      if (bus.coefi !== COEF_W'(k) || bus.coefi_valid !== 1'b1 ||
          bus.busy !== 1'b1 || bus.data_en !== 1'b0) begin
        fails++;
        $display("[TB] FAIL basic_stream cycle %0d: coefi=%0h valid=%0b busy=%0b den=%0b, expected %0h 1 1 0",
                 k, bus.coefi, bus.coefi_valid, bus.busy, bus.data_en, k);
      end
      tick();
    end
    tests++;
    if (bus.coef_on !== 1'b1 || bus.coef_sel !== 4'd3 ||
        bus.coefi_valid !== 1'b0 || bus.coefi !== '0) begin
      fails++;
      $display("[TB] FAIL basic_switch: on=%0b sel=%0h valid=%0b coefi=%0h, expected 1 3 0 0",
               bus.coef_on, bus.coef_sel, bus.coefi_valid, bus.coefi);
    end
    tick();
    for (int c = 13; c <= 23; c++) begin
      tests++;
      if (bus.data_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1 ||
          bus.coef_on !== 1'b0 || bus.coef_sel !== 4'd3 || bus.coefi !== '0) begin
        fails++;
        $display("[TB] FAIL basic_settle cycle %0d: den=%0b done=%0b busy=%0b on=%0b sel=%0h coefi=%0h, expected 0 0 1 0 3 0",
                 c, bus.data_en, bus.done, bus.busy, bus.coef_on, bus.coef_sel, bus.coefi);
      end
      tick();
    end
    tests++;
    if (bus.done !== 1'b1 || bus.data_en !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_done: done=%0b den=%0b busy=%0b, expected 1 1 0",
               bus.done, bus.data_en, bus.busy);
    end
    tick();
    tests++;
    if (bus.done !== 1'b0 || bus.data_en !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_after_done: done=%0b den=%0b, expected 0 1", bus.done, bus.data_en);
    end
  endtask

  task automatic test_bad_addr();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd11;
    bus.cfg_data = 12'd5;
    tick();
    bus.cfg_we = 1'b0;
    tests++;
    if (bus.err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bad_addr_err: err=%0b, expected 1", bus.err);
    end
    tick();
    tests++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bad_addr_err_clear: err=%0b, expected 0", bus.err);
    end
    start_load(4'd4);
    for (int k = 1; k <= TAPS; k++) begin
      tests++;
      if (bus.coefi !== COEF_W'(k)) begin
        fails++;
        $display("[TB] FAIL bad_addr_stream cycle %0d: coefi=%0h, expected %0h", k, bus.coefi, k);
      end
      tick();
    end
    tests++;
    if (bus.coef_on !== 1'b1 || bus.coef_sel !== 4'd4) begin
      fails++;
      $display("[TB] FAIL bad_addr_switch: on=%0b sel=%0h, expected 1 4", bus.coef_on, bus.coef_sel);
    end
    repeat (12) tick();
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bad_addr_done: done=%0b, expected 1", bus.done);
    end
    tick();
  endtask

  task automatic test_same_edge();
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd0;
    bus.cfg_data  = 12'hFF9;
    shadow_exp[0] = 12'hFF9;
    start_load(4'd5);
    bus.cfg_we = 1'b0;
    tests++;
    if (bus.coefi !== 12'hFF9 || bus.coefi_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL same_edge_first: coefi=%0h valid=%0b, expected ff9 1", bus.coefi, bus.coefi_valid);
    end
    for (int k = 2; k <= TAPS; k++) begin
      tick();
      tests++;
      if (bus.coefi !== COEF_W'(k)) begin
        fails++;
        $display("[TB] FAIL same_edge_stream cycle %0d: coefi=%0h, expected %0h", k, bus.coefi, k);
      end
    end
    tick();
    repeat (12) tick();
    tests++;
    if (bus.done !== 1'b1 || bus.coef_sel !== 4'd5) begin
      fails++;
      $display("[TB] FAIL same_edge_done: done=%0b sel=%0h, expected 1 5", bus.done, bus.coef_sel);
    end
    tick();
  endtask

  task automatic test_busy_reject();
    int   done_cnt;
    logic exp_err;
    done_cnt = 0;
    start_load(4'd6);
    for (int c = 1; c <= 30; c++) begin
      if (c <= TAPS) begin
        tests++;
        if (bus.coefi !== shadow_exp[c-1]) begin
          fails++;
          $display("[TB] FAIL reject_stream cycle %0d: coefi=%0h, expected %0h", c, bus.coefi, shadow_exp[c-1]);
        end
      end
      exp_err = (c == 6);
      tests++;
      if (bus.err !== exp_err) begin
        fails++;
        $display("[TB] FAIL reject_err cycle %0d: err=%0b, expected %0b", c, bus.err, exp_err);
      end
      if (bus.done === 1'b1) done_cnt++;
      if (c == 5) begin
        bus.load_req = 1'b1;
        bus.load_sel = 4'd9;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'd2;
        bus.cfg_data = 12'h064;
      end
      tick();
      bus.load_req = 1'b0;
      bus.cfg_we   = 1'b0;
    end
    tests++;
    if (done_cnt !== 1 || bus.coef_sel !== 4'd6) begin
      fails++;
      $display("[TB] FAIL reject_done_count: done pulses=%0d sel=%0h, expected 1 6", done_cnt, bus.coef_sel);
    end
  endtask

  task automatic test_back_to_back();
    start_load(4'd1);
    for (int c = 1; c < 24; c++) begin
      if (c <= TAPS) begin
        tests++;
        if (bus.coefi !== shadow_exp[c-1]) begin
          fails++;
          $display("[TB] FAIL b2b_first_stream cycle %0d: coefi=%0h, expected %0h", c, bus.coefi, shadow_exp[c-1]);
        end
      end
      tick();
    end
    tests++;
    if (bus.done !== 1'b1 || bus.coef_sel !== 4'd1) begin
      fails++;
      $display("[TB] FAIL b2b_first_done: done=%0b sel=%0h, expected 1 1", bus.done, bus.coef_sel);
    end
    for (int g = 0; g < 3; g++) begin
      tick();
      tests++;
      if (bus.coef_sel !== 4'd1 || bus.data_en !== 1'b1) begin
        fails++;
        $display("[TB] FAIL b2b_gap cycle %0d: sel=%0h den=%0b, expected 1 1", g, bus.coef_sel, bus.data_en);
      end
    end
    start_load(4'd2);
    for (int c = 1; c < 24; c++) begin
      if (c == TAPS) begin
        tests++;
        if (bus.coef_sel !== 4'd1) begin
          fails++;
          $display("[TB] FAIL b2b_sel_hold: sel=%0h, expected 1", bus.coef_sel);
        end
      end
      if (c == TAPS + 1) begin
        tests++;
        if (bus.coef_sel !== 4'd2 || bus.coef_on !== 1'b1) begin
          fails++;
          $display("[TB] FAIL b2b_second_switch: sel=%0h on=%0b, expected 2 1", bus.coef_sel, bus.coef_on);
        end
      end
      tick();
    end
    tests++;
    if (bus.done !== 1'b1 || bus.coef_sel !== 4'd2) begin
      fails++;
      $display("[TB] FAIL b2b_second_done: done=%0b sel=%0h, expected 1 2", bus.done, bus.coef_sel);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_load(4'd7);
    repeat (14) tick();
    tests++;
    if (bus.busy !== 1'b1 || bus.data_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_in_settle: busy=%0b den=%0b, expected 1 0", bus.busy, bus.data_en);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.coefi, bus.coefi_valid, bus.coef_sel, bus.coef_on, bus.data_en,
         bus.busy, bus.done, bus.err} !== '0) begin
      fails++;
      $display("[TB] FAIL mid_async_reset: coefi=%0h valid=%0b sel=%0h on=%0b den=%0b busy=%0b done=%0b err=%0b, expected all 0",
               bus.coefi, bus.coefi_valid, bus.coef_sel, bus.coef_on, bus.data_en,
               bus.busy, bus.done, bus.err);
    end
    for (int i = 0; i < TAPS; i++) shadow_exp[i] = '0;
    repeat (2) tick();
    tests++;
    if (bus.done !== 1'b0 || bus.data_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_hold: done=%0b den=%0b, expected 0 0", bus.done, bus.data_en);
    end
    reset = 1'b0;
    start_load(4'd6);
    tests++;
    if (bus.busy !== 1'b1 || bus.coefi_valid !== 1'b1 || bus.coef_sel !== 4'd0) begin
      fails++;
      $display("[TB] FAIL mid_first_accept: busy=%0b valid=%0b sel=%0h, expected 1 1 0",
               bus.busy, bus.coefi_valid, bus.coef_sel);
    end
    for (int c = 1; c < 24; c++) begin
      tests++;
      if (bus.data_en !== 1'b0 || bus.done !== 1'b0 ||
          (c <= TAPS && bus.coefi !== shadow_exp[c-1])) begin
        fails++;
        $display("[TB] FAIL mid_reload cycle %0d: den=%0b done=%0b coefi=%0h, expected 0 0 0",
                 c, bus.data_en, bus.done, bus.coefi);
      end
      tick();
    end
    tests++;
    if (bus.done !== 1'b1 || bus.data_en !== 1'b1 || bus.coef_sel !== 4'd6) begin
      fails++;
      $display("[TB] FAIL mid_reload_done: done=%0b den=%0b sel=%0h, expected 1 1 6",
               bus.done, bus.data_en, bus.coef_sel);
    end
    tick();
  endtask

  // Bound the whole run in case the sequencer never finishes
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_load();
    test_bad_addr();
    test_same_edge();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter TAPS, default 11, number of FIR taps loaded per reload.
REQ-002 Parameter COEF_W, default 12, coefficient width, two's complement.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_we  in  1  coefficient shadow-register write strobe.
REQ-006 cfg_addr  in  4  tap index for write.
REQ-007 cfg_data  in  COEF_W  coefficient value for write.
REQ-008 load_req  in  1  request to stream the shadow set into the FIR.
REQ-009 load_sel  in  4  coefficient-set select applied at the end of the load.
REQ-010 coefi  out  COEF_W  coefficient to FIR.
REQ-011 coefi_valid  out  1  coefi qualifier.
REQ-012 coef_sel  out  4  active set select to FIR.
REQ-013 coef_on  out  1  one-cycle set-switch strobe to FIR.
REQ-014 data_en  out  1  gates FIR datai_valid for both I and Q filters.
REQ-015 busy  out  1  high while a load sequence is in progress.
REQ-016 done  out  1  one-cycle pulse at sequence completion.
REQ-017 err  out  1  one-cycle pulse on a rejected request.

Function
REQ-018 Shadow register file: TAPS entries of COEF_W bits; all outputs registered.
REQ-019 FSM states IDLE, LOAD, SWITCH, SETTLE; one state per cycle group as below.
REQ-020 IDLE: cfg_we with cfg_addr < TAPS writes cfg_data to entry cfg_addr at that edge.
REQ-021 IDLE: cfg_we with cfg_addr >= TAPS drops the write and pulses err next cycle.
REQ-022 IDLE: load_req at edge N captures load_sel, enters LOAD; busy=1 and data_en=0 from cycle N+1.
REQ-023 Same-edge cfg_we and load_req in IDLE: write commits first; LOAD streams the updated value.
REQ-024 LOAD: cycles N+1..N+TAPS drive coefi = entry k, k = 0..TAPS-1 ascending, coefi_valid=1.
REQ-025 SWITCH: cycle N+TAPS+1 drives coef_on=1, coef_sel = captured load_sel; coefi_valid=0.
REQ-026 coef_sel holds its value from SWITCH until the next SWITCH or reset.
REQ-027 SETTLE: TAPS cycles (N+TAPS+2..N+2*TAPS+1) with data_en=0 to flush the filter pipeline.
REQ-028 Cycle N+2*TAPS+2: state IDLE, busy=0, done=1 for one cycle, data_en=1.
REQ-029 data_en stays 0 after reset until the first completed sequence; then 1 in IDLE.
REQ-030 load_req while busy: ignored, no state change, err pulse next cycle.
REQ-031 cfg_we while busy: write dropped, err pulse next cycle; shadow file unchanged.
REQ-032 Simultaneous rejected cfg_we and load_req: single err pulse.
REQ-033 coefi holds 0 whenever coefi_valid=0.
REQ-034 Index counter wraps only via state exit; never exceeds TAPS-1.

Reset
REQ-035 reset=1 forces, asynchronously: state IDLE, shadow file all 0, coefi 0, coefi_valid 0, coef_sel 0, coef_on 0, data_en 0, busy 0, done 0, err 0.
REQ-036 reset asserted mid-sequence aborts it; no done pulse; data_en stays 0 until a new full sequence completes.
REQ-037 First load_req is accepted at the first rising edge after reset deasserts.

Verification
REQ-038 Write entries 0..10 = 1..11, load_req with load_sel=3 -> coefi 1..11 on 11 consecutive valid cycles, coef_on with coef_sel=3 at cycle 12, done at cycle 24, data_en=1 from cycle 24.
REQ-039 cfg_we addr=11 data=5 in IDLE -> err pulse, entry contents unchanged, subsequent load streams prior values.
REQ-040 load_req and cfg_we addr=0 data=-7 same edge -> first streamed coefi = -7 (0xFF9).
REQ-041 load_req and cfg_we during LOAD cycle 5 -> err pulses, stream unchanged, one done only.
REQ-042 reset asserted during SETTLE -> all outputs 0 immediately, shadow file 0, no done, data_en 0 until next full sequence.
REQ-043 Two back-to-back loads (sel 1 then 2) -> coef_sel 1 held through IDLE gap, then 2 after second SWITCH.
